// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding and baud constant for the FIFO UART transmitter
package fifo_uart_tx_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam int CLKS_PER_BIT_9600 = 5208;
endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick: bit-period counter with synchronous clear and terminal-count tick
module baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  // count 0..CLKS_PER_BIT-1, wrapping on tick so each bit period restarts at 0
  always_ff @(posedge clk)
    cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO and sends each byte as an 8N1 UART frame (FIFO_UART_TX_PARITY_EN adds even parity)
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             empty,
  input  logic [B-1:0]     r_data,
  output logic             rd,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt
);
  localparam int IW = B > 1 ? $clog2(B) : 1;
  logic [2:0]    state;
  logic [B-1:0]  shift;
  logic [B-1:0]  shift_nx;
  logic [IW-1:0] idx;
  logic          tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par;
`endif
  assign shift_nx = shift >> 1;
  // the counter is held at 0 while idle, so START always begins a full bit period
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .clr  (clr || state == IDLE),
    .tick (tick)
  );
  // frame sequencer: pop, start bit, data bits LSB first, optional parity, stop bit
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      tx       <= 1'b1;
      rd       <= 1'b0;
      busy     <= 1'b0;
      sent_cnt <= '0;
      shift    <= '0;
      idx      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rd) begin
            rd    <= 1'b0;
            shift <= r_data;
`ifdef FIFO_UART_TX_PARITY_EN
            par   <= ^r_data;
`endif
            tx    <= 1'b0;
            state <= START;
          end else if (!empty) begin
            rd   <= 1'b1;
            busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            idx   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == IW'(B - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift <= shift_nx;
              tx    <= shift_nx[0];
              idx   <= idx + 1'b1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            busy     <= 1'b0;
            sent_cnt <= sent_cnt + 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          rd    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench with FIFO model, UART line decoder and frame timing checks
module tb_fifo_uart_tx;
  localparam int C = 4;
  localparam int B = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = 1 + (B + 2 + P) * C;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic rd, tx, busy;
  logic [7:0] sent_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int rd_n = 0;
  int cyc = 0;
  int rd_times[$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic manual = 1'b0;
  logic man_empty = 1'b1;
  logic [7:0] man_data = 8'h00;

  always #5 clk = ~clk;

  fifo_uart_tx #(.B(B), .CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .empty    (empty),
    .r_data   (r_data),
    .rd       (rd),
    .tx       (tx),
    .busy     (busy),
    .sent_cnt (sent_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // FIFO model: a pop takes effect after the edge that ends the rd cycle
  initial begin
    logic was_rd;
    forever begin
      @(negedge clk);
      was_rd = rd;
      @(posedge clk);
      #1;
      if (was_rd === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
      empty = manual ? man_empty : (fifo_q.size() == 0);
      r_data = manual ? man_data : (fifo_q.size() > 0 ? fifo_q[0] : r_data);
    end
  end

  // rd pulse monitor
  initial forever begin
    @(negedge clk);
    if (rd === 1'b1) begin
      rd_n++;
      rd_times.push_back(cyc);
    end
  end

  task automatic wait_bits(input int n, inout logic ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ab = ab | (clr === 1'b1);
    end
  endtask

  // line decoder: samples mid-bit and checks each frame against the scoreboard
  initial begin
    logic ab, s0, pb, sp;
    logic [7:0] d, e;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ab = 1'b0;
        pb = 1'b0;
        wait_bits(C / 2, ab);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          wait_bits(C, ab);
          d[i] = tx;
        end
        if (P == 1) begin
          wait_bits(C, ab);
          pb = tx;
        end
        wait_bits(C, ab);
        sp = tx;
        if (ab) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got %0h expected none", d);
        end else begin
          e = exp_q.pop_front();
          chk("start_bit", 32'(s0), 32'd0);
          chk("data_byte", 32'(d), 32'(e));
          if (P == 1) chk("parity_bit", 32'(pb), 32'(^e));
          chk("stop_bit", 32'(sp), 32'd1);
        end
      end
    end
  end

  task automatic wait_rd(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rd === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL rd_timeout: got no rd expected rd within 100 cycles");
    end
  endtask

  task automatic wait_cnt(input logic [7:0] target, input int limit);
    int i;
    for (i = 0; i < limit && sent_cnt !== target; i++) @(negedge clk);
    if (sent_cnt !== target) begin
      n_cmp++;
      n_err++;
      $display("FAIL cnt_timeout: got %0h expected %0h", sent_cnt, target);
    end
  endtask

  // one frame with exact rd-to-count timing
  task automatic send_one(input logic [7:0] b);
    logic [7:0] s0;
    logic ok;
    s0 = sent_cnt;
    push(b);
    wait_rd(ok);
    if (ok) begin
      repeat (FRAME - 1) @(negedge clk);
      chk("cnt_before_end", 32'(sent_cnt), 32'(s0));
      chk("busy_before_end", 32'(busy), 32'd1);
      @(negedge clk);
      chk("cnt_at_end", 32'(sent_cnt), 32'(8'(s0 + 8'd1)));
      chk("busy_at_end", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int r0, n;
    logic ok, tx_low, busy_hi;
    logic [7:0] s0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(sent_cnt), 32'd0);
    tx_low = 1'b0;
    busy_hi = 1'b0;
    repeat (100) begin
      @(negedge clk);
      tx_low = tx_low | (tx !== 1'b1);
      busy_hi = busy_hi | (busy !== 1'b0);
    end
    chk("idle_tx_low", 32'(tx_low), 32'd0);
    chk("idle_busy", 32'(busy_hi), 32'd0);
    chk("idle_rd_pulses", 32'(rd_n), 32'd0);
    chk("idle_cnt", 32'(sent_cnt), 32'd0);

    send_one(8'hA5);
    chk("a5_rd_pulses", 32'(rd_n), 32'd1);

    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    r0 = rd_n;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_cnt(8'd3, 600);
    chk("b2b_cnt", 32'(sent_cnt), 32'd3);
    chk("b2b_rd_pulses", 32'(rd_n - r0), 32'd3);
    if (rd_n - r0 >= 3) begin
      chk("b2b_gap1", 32'(rd_times[r0 + 1] - rd_times[r0]), 32'(FRAME + 1));
      chk("b2b_gap2", 32'(rd_times[r0 + 2] - rd_times[r0 + 1]), 32'(FRAME + 1));
    end
    repeat (5) @(negedge clk);

    r0 = rd_n;
    push(8'h3C);
    wait_rd(ok);
    repeat (8) @(negedge clk);
    manual = 1'b1;
    man_data = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      man_empty = (k % 2 == 1);
      @(negedge clk);
    end
    manual = 1'b0;
    repeat (25) @(negedge clk);
    chk("frozen_rd_pulses", 32'(rd_n - r0), 32'd1);
    chk("frozen_cnt", 32'(sent_cnt), 32'd4);

    push(8'h5A);
    wait_rd(ok);
    repeat (22) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cnt", 32'(sent_cnt), 32'd0);
    chk("abort_rd", 32'(rd), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    r0 = rd_n;
    repeat (60) @(negedge clk);
    chk("abort_no_reread", 32'(rd_n - r0), 32'd0);
    chk("abort_idle_tx", 32'(tx), 32'd1);

    send_one(8'h07);
    send_one(8'h03);
    chk("par_cnt", 32'(sent_cnt), 32'd2);

    r0 = rd_n;
    s0 = sent_cnt;
    n = 16;
    for (int i = 0; i < n; i++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_cnt(8'(s0 + 8'(n)), 2000);
    chk("rand_cnt", 32'(sent_cnt), 32'(8'(s0 + 8'(n))));
    chk("rand_rd_pulses", 32'(rd_n - r0), 32'(n));
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the button-driven FIFO buffer: pops bytes from the FIFO whenever it is non-empty and transmits each one serially, LSB first, in 8N1 UART framing on a single output pin. Sits between the FIFO's read port (empty flag, read-data bus, read strobe) and the board's TX pin. It replaces the manual read button so stored bytes drain automatically to a host.

## Interface
- B, 8, data width; equals the FIFO word width.
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- CNT_W, 8, width of the sent-byte counter.

- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- empty  in  1  FIFO empty flag; high means no data.
- r_data  in  B  FIFO read data at the current read address; combinational from the FIFO register file.
- rd  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the pop cycle through the end of the stop bit.
- sent_cnt  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, START, DATA, STOP (PARITY is added with the macro).
- IDLE: tx=1, busy=0. When empty=0, assert rd for exactly one cycle, capture r_data into the shift register on the same edge, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the index. After bit B-1 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, increment sent_cnt and return to IDLE.
- Baud counter: reloads to 0 on every state entry and counts 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT).
- rd is never asserted outside IDLE, and never while empty=1.
- Changes to empty or r_data during a frame have no effect; the captured byte is frozen.
- Reset mid-frame: on the next edge tx=1, rd=0, busy=0, state=IDLE, sent_cnt=0. The byte already popped is discarded and is not re-read.
- Reset values: tx=1, rd=0, busy=0, sent_cnt=0, shift register=0.

## Timing
- Pop-to-start latency: rd is high in cycle n; tx falls at the edge ending cycle n, so the start bit occupies cycles n+1..n+CLKS_PER_BIT.
- Frame length: 1 + (B+2)·CLKS_PER_BIT cycles from rd to the next IDLE cycle. With PARITY_EN it is 1 + (B+3)·CLKS_PER_BIT.
- Back-to-back: if empty=0 in the first IDLE cycle after STOP, rd is asserted in that cycle. The minimum gap is 1 cycle of idle-high between the stop bit and the next start bit.
- The FIFO updates empty one cycle after rd. The IDLE decision always happens at least one cycle after the previous rd, so no double-pop is possible.
- sent_cnt updates on the final STOP edge; busy falls on that same edge.
- Outputs tx, rd and busy are registered; no combinational path from inputs to outputs.

## Configuration
- FIFO_UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the B data bits) for CLKS_PER_BIT cycles.
- Not defined: 8N1 framing only, and no parity logic is synthesized.

## Structure
- A shared package holds:
  - the state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4, 3-bit);
  - the default baud constant for 50 MHz/9600.
- One sub-module, baud_tick: a counter with synchronous clear and terminal-count output tick, parameterized by CLKS_PER_BIT. The top FSM clears it on state entry.

## Test plan
Bench uses CLKS_PER_BIT=4, B=8.
- After reset, hold empty=1 for 100 cycles: tx stays 1, rd never pulses, busy=0, sent_cnt=0.
- r_data=8'hA5, drop empty for 1 cycle:
  - exactly one rd pulse;
  - tx samples mid-bit show 0, 1,0,1,0,0,1,0,1, 1;
  - sent_cnt=1 at cycle 41 after rd.
- Hold empty=0 with FIFO model bytes 8'h01, 8'h02, 8'h03:
  - three rd pulses spaced exactly 42 cycles apart;
  - decoded bytes appear in order;
  - sent_cnt=3.
- Toggle empty and change r_data to 8'hFF during the DATA state of a frame carrying 8'h3C: the frame still decodes 8'h3C, with no extra rd.
- Assert clr during bit 4 of a frame: next cycle tx=1, busy=0, sent_cnt=0. With empty=1 afterwards, no further rd.
- With FIFO_UART_TX_PARITY_EN defined:
  - send 8'h07: parity bit 1, frame 45 cycles;
  - send 8'h03: parity bit 0.
